// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
// The optional IFETCH_PERF_EN build adds perf counters in ins_fetch; nothing here depends on it.
package riscv_fetch_pkg;

    localparam int          ILEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [ILEN-1:0] pc;
        logic            mis;
    } fetch_entry_t;

    function automatic logic [ILEN-1:0] align_word(input logic [ILEN-1:0] addr);
        return {addr[ILEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch queue between the instruction memory response and decode.
// Flush has priority over push/pop; push+pop in the same cycle is legal at any occupancy.
module fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  fetch_entry_t     push_entry_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] count_o,
    output logic             valid_o,
    output fetch_entry_t     head_o
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i & (count_q != '0);
    // A push into a full queue is only accepted when the head leaves in the same cycle.
    assign do_push = push_i & (!full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_entry_i;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;
    assign valid_o = (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];

    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !pop_i && !flush_i && full));

endmodule

// File: rtl/ins_fetch.sv
// RV32I fetch stage: owns the PC, issues one-cycle-latency reads to ins_mem and queues results for decode.
// Define IFETCH_PERF_EN to add saturating fetch/stall/flush counters on perf_*_o.
module ins_fetch
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_en_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_en_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
`ifdef IFETCH_PERF_EN
    output logic        id_misalign_o,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_stall_o,
    output logic [31:0] perf_flush_o
`else
    output logic        id_misalign_o
`endif
);

    localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      tag_q, tag_d;
    logic             inflight_q, inflight_d;
    logic             mis_q, mis_d;

    logic [CNT_W-1:0] fq_count;
    logic             fq_valid;
    fetch_entry_t     fq_head;
    fetch_entry_t     push_entry;
    logic             pop;
    logic             push;
    logic             issue;
    logic [CNT_W:0]   occupancy;

    assign pop = fq_valid & id_ready_i;

    // Slots already claimed once this cycle's pop and the outstanding response are accounted for.
    assign occupancy = {1'b0, fq_count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);

    // Gating with reset_n keeps the request port quiet while reset is held.
    assign issue       = reset_n & ((fetch_en_i & (occupancy < (CNT_W+1)'(FQ_DEPTH))) | redirect_i);
    assign imem_en_o   = issue;
    assign imem_addr_o = (redirect_i && reset_n) ? align_word(redirect_pc_i) : pc_q;

    assign push       = inflight_q & !redirect_i;
    assign push_entry = '{instr: imem_rdata_i, pc: tag_q, mis: mis_q};

    always_comb begin
        pc_d       = pc_q;
        tag_d      = tag_q;
        mis_d      = mis_q;
        inflight_d = issue;
        if (issue) begin
            pc_d  = imem_addr_o + 32'd4;
            tag_d = imem_addr_o;
            mis_d = redirect_i & (redirect_pc_i[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            tag_q      <= RESET_PC;
            mis_q      <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            mis_q      <= mis_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FQ_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (reset_n),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .flush_i      (redirect_i),
        .count_o      (fq_count),
        .valid_o      (fq_valid),
        .head_o       (fq_head)
    );

    assign id_valid_o    = fq_valid;
    assign id_instr_o    = fq_valid ? fq_head.instr : NOP_INSTR;
    assign id_pc_o       = fq_valid ? fq_head.pc    : 32'h0;
    assign id_misalign_o = fq_valid & fq_head.mis;

`ifdef IFETCH_PERF_EN
    logic [2:0]  perf_evt;
    logic [31:0] perf_cnt [3];

    // Only pushed responses count as fetches, so a squashed word never reaches perf_fetch_o.
    assign perf_evt = {redirect_i, fq_valid & !id_ready_i, push};

    for (genvar gi = 0; gi < 3; gi++) begin : g_perf
        logic [31:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (perf_evt[gi] && (cnt_q != 32'hFFFF_FFFF)) begin
                cnt_d = cnt_q + 32'd1;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign perf_cnt[gi] = cnt_q;
    end

    assign perf_fetch_o = perf_cnt[0];
    assign perf_stall_o = perf_cnt[1];
    assign perf_flush_o = perf_cnt[2];
`else
    // Without the perf build there are no counters to maintain.
`endif

endmodule
